// File: rtl/fp_pkg.sv
// Shared binary64 constants and pipeline payload types for the normalise-and-round stage.
package fp_pkg;

  localparam int unsigned FP64_BIAS    = 1023;
  localparam int unsigned FP64_EXP_W   = 11;
  localparam int unsigned FP64_FRAC_W  = 52;
  localparam int unsigned FP64_EXP_MAX = 2047;

  // Internal signed exponent width; wide enough for in_exp - lz + 1 at any legal W_EXP/W_MANT.
  localparam int unsigned EXP_IW = 16;

  typedef struct packed {
    logic                   sign;
    logic [FP64_EXP_W-1:0]  exp;
    logic [FP64_FRAC_W-1:0] frac;
  } fp64_t;

  typedef struct packed {
    logic                     sign;
    logic                     zero;
    logic        [EXP_IW-1:0] lz;
    logic signed [EXP_IW-1:0] exp;
  } s1_t;

  typedef struct packed {
    logic                     sign;
    logic                     zero;
    logic signed [EXP_IW-1:0] exp_n;
    logic [FP64_FRAC_W-1:0]   frac;
    logic                     lsb;
    logic                     guard;
    logic                     sticky;
  } s2_t;

endpackage

// File: rtl/fp_norm_round_clz.sv
// Combinational leading-zero counter; an all-zero input yields W_IN.
module fp_norm_round_clz #(
  parameter int unsigned W_IN = 64
) (
  input  logic [W_IN-1:0]        data,
  output logic [$clog2(W_IN):0]  count
);

  localparam int unsigned CNT_W = $clog2(W_IN) + 1;

  // Scanning upward lets the highest set bit win.
  always_comb begin
    count = CNT_W'(W_IN);
    for (int i = 0; i < int'(W_IN); i++) begin
      if (data[i]) count = CNT_W'(W_IN - 1 - i);
    end
  end

endmodule

// File: rtl/fp_norm_round.sv
// Three-stage normalise, round-to-nearest-even and binary64 pack, valid/ready on both sides.
module fp_norm_round
  import fp_pkg::*;
#(
  parameter int unsigned W_MANT = 64,
  parameter int unsigned W_EXP  = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [W_EXP-1:0]  in_exp,
  input  logic [W_MANT-1:0] in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_data,
  output logic              out_inexact,
  output logic              out_overflow,
  output logic              out_underflow
);

  localparam int unsigned CNT_W = $clog2(W_MANT) + 1;
  localparam logic signed [EXP_IW-1:0] ExpMax = EXP_IW'(FP64_EXP_MAX);

  logic [CNT_W-1:0]  lz;
  logic              v1, v2, v3;
  logic              ld1, ld2, ld3;
  s1_t               s1_d, s1_q;
  logic [W_MANT-1:0] mant_q;
  s2_t               s2_d, s2_q;
  fp64_t             res_d, res_q;
  logic              inexact_d, inexact_q;
  logic              ovf_d, ovf_q;
  logic              unf_d, unf_q;

  logic [W_MANT-2:0]        shifted;
  logic                     inc;
  logic [FP64_FRAC_W:0]     frac_r;
  logic signed [EXP_IW-1:0] exp_r;

  fp_norm_round_clz #(
    .W_IN (W_MANT)
  ) u_clz (
    .data  (in_mant),
    .count (lz)
  );

  // Each stage loads when empty or when its successor is taking its word.
  assign ld3      = !v3 || out_ready;
  assign ld2      = !v2 || ld3;
  assign ld1      = !v1 || ld2;
  assign in_ready = ld1;

  always_comb begin
    s1_d.sign = in_sign;
    s1_d.zero = ~|in_mant;
    s1_d.lz   = EXP_IW'(lz);
    s1_d.exp  = EXP_IW'($signed(in_exp));
  end

  // The normalised msb is the implicit one and is dropped.
  always_comb begin
    shifted     = (W_MANT-1)'(mant_q << s1_q.lz);
    s2_d.sign   = s1_q.sign;
    s2_d.zero   = s1_q.zero;
    s2_d.exp_n  = s1_q.exp - $signed(s1_q.lz);
    s2_d.frac   = shifted[W_MANT-2 -: FP64_FRAC_W];
    s2_d.lsb    = shifted[W_MANT-53];
    s2_d.guard  = shifted[W_MANT-54];
    s2_d.sticky = |shifted[W_MANT-55:0];
  end

  always_comb begin
    inc       = s2_q.guard & (s2_q.sticky | s2_q.lsb);
    frac_r    = {1'b0, s2_q.frac} + (FP64_FRAC_W+1)'(inc);
    exp_r     = s2_q.exp_n + $signed({{(EXP_IW-1){1'b0}}, frac_r[FP64_FRAC_W]});
    res_d     = '{sign: s2_q.sign, exp: exp_r[FP64_EXP_W-1:0], frac: frac_r[FP64_FRAC_W-1:0]};
    inexact_d = s2_q.guard | s2_q.sticky;
    ovf_d     = 1'b0;
    unf_d     = 1'b0;
    if (s2_q.zero) begin
      res_d.exp  = '0;
      res_d.frac = '0;
      inexact_d  = 1'b0;
    end else if (exp_r >= ExpMax) begin
      res_d.exp  = '1;
      res_d.frac = '0;
      ovf_d      = 1'b1;
      inexact_d  = 1'b1;
    end else if (exp_r <= 0) begin
      res_d.exp  = '0;
      res_d.frac = '0;
      unf_d      = 1'b1;
      inexact_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      s1_q      <= '0;
      mant_q    <= '0;
      s2_q      <= '0;
      res_q     <= '0;
      inexact_q <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      if (ld1) v1 <= in_valid;
      if (ld2) v2 <= v1;
      if (ld3) v3 <= v2;
      if (in_valid && ld1) begin
        s1_q   <= s1_d;
        mant_q <= in_mant;
      end
      if (v1 && ld2) s2_q <= s2_d;
      if (v2 && ld3) begin
        res_q     <= res_d;
        inexact_q <= inexact_d;
        ovf_q     <= ovf_d;
        unf_q     <= unf_d;
      end
    end
  end

  assign out_valid     = v3;
  assign out_data      = res_q;
  assign out_inexact   = inexact_q;
  assign out_overflow  = ovf_q;
  assign out_underflow = unf_q;

endmodule

// File: tb/tb_fp_norm_round.sv
// Directed bench for fp_norm_round: rounding, boundaries, backpressure and mid-flight reset.
module tb_fp_norm_round;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [12:0] in_exp = '0;
  logic [63:0] in_mant = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_data;
  logic        out_inexact, out_overflow, out_underflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp_norm_round #(
    .W_MANT (64),
    .W_EXP  (13)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_exp        (in_exp),
    .in_mant       (in_mant),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_inexact   (out_inexact),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Send one word with out_ready high; check latency, data and {inexact, overflow, underflow}.
  task automatic run_one(input string tag, input logic s, input logic [12:0] e,
                         input logic [63:0] m, input logic [63:0] want, input logic [2:0] flags);
    int n;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_sign   = s;
    in_exp    = e;
    in_mant   = m;
    #1 check({tag, ".rdy"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
    end
    check({tag, ".lat"}, 64'(n), 64'd3);
    check({tag, ".data"}, out_data, want);
    check({tag, ".flags"}, 64'({out_inexact, out_overflow, out_underflow}), 64'(flags));
  endtask

  initial begin
    logic [63:0] bp_want [6];
    logic [63:0] held;
    logic        holding;
    int          tx, rx, stale;

    #3;
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.out_data", out_data, 64'd0);
    check("rst.flags", 64'({out_inexact, out_overflow, out_underflow}), 64'd0);
    check("rst.in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    run_one("one",     1'b0, 13'd1023, 64'h8000_0000_0000_0000, 64'h3FF0_0000_0000_0000, 3'b000);
    run_one("lz_pos",  1'b0, 13'd1086, 64'h0000_0000_0000_0001, 64'h3FF0_0000_0000_0000, 3'b000);
    run_one("lz_neg",  1'b1, 13'd1086, 64'h0000_0000_0000_0001, 64'hBFF0_0000_0000_0000, 3'b000);
    run_one("tie_even", 1'b0, 13'd1023, 64'h8000_0000_0000_0400, 64'h3FF0_0000_0000_0000, 3'b100);
    run_one("tie_odd", 1'b0, 13'd1023, 64'h8000_0000_0000_0C00, 64'h3FF0_0000_0000_0002, 3'b100);
    run_one("carry",   1'b0, 13'd1023, 64'hFFFF_FFFF_FFFF_FC00, 64'h4000_0000_0000_0000, 3'b100);
    run_one("ovf",     1'b0, 13'd2047, 64'h8000_0000_0000_0000, 64'h7FF0_0000_0000_0000, 3'b110);
    run_one("unf",     1'b0, 13'd0,    64'h8000_0000_0000_0000, 64'h0000_0000_0000_0000, 3'b101);
    run_one("zero",    1'b1, 13'd1023, 64'h0000_0000_0000_0000, 64'h8000_0000_0000_0000, 3'b000);

    // Backpressure: word k is 1.k * 2^k with the fraction's low bits holding k.
    for (int k = 0; k < 6; k++) bp_want[k] = {1'b0, 11'(1023 + k), 52'(k)};
    tx = 0;
    rx = 0;
    holding = 1'b0;
    held = '0;
    for (int c = 0; c < 40 && rx < 6; c++) begin
      @(negedge clk);
      out_ready = (c >= 5);
      in_valid  = (tx < 6);
      in_sign   = 1'b0;
      in_exp    = 13'(1023 + tx);
      in_mant   = 64'h8000_0000_0000_0000 | (64'(tx) << 11);
      #1;
      if (c == 3 || c == 4) check("bp.in_ready_low", 64'(in_ready), 64'd0);
      if (c == 3) check("bp.accepted", 64'(tx), 64'd3);
      if (holding) check("bp.hold", out_data, held);
      if (out_valid && out_ready) begin
        check("bp.order", out_data, bp_want[rx]);
        rx++;
      end
      holding = out_valid && !out_ready;
      held    = out_data;
      if (in_valid && in_ready) tx++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("bp.sent", 64'(tx), 64'd6);
    check("bp.recv", 64'(rx), 64'd6);

    // Mid-flight reset with three words in the pipe.
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_exp   = 13'd1023;
      in_mant  = 64'h8000_0000_0000_0000;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("rst2.pre_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst2.out_valid", 64'(out_valid), 64'd0);
    check("rst2.out_data", out_data, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("rst2.stale", 64'(stale), 64'd0);
    run_one("post_rst", 1'b0, 13'd1024, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
